// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer port-A loader.
package fb_pkg;

  localparam int unsigned FB_BYTE_ADDR_W = 12;
  localparam int unsigned FB_WORD_ADDR_W = 11;
  localparam int unsigned FB_BYTES       = 4096;

  localparam logic [7:0] CMD_FRAME_DEF = 8'h46;
  localparam logic [7:0] CMD_PIXEL_DEF = 8'h50;

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    PIX_AH,
    PIX_AL,
    PIX_DL,
    PIX_DH
  } fbl_state_e;

  // One port-A byte write.
  typedef struct packed {
    logic [FB_BYTE_ADDR_W-1:0] addr;
    logic [7:0]                data;
  } fb_wr_t;

endpackage

// File: rtl/framebuffer_loader_if.sv
// UART byte input and framebuffer port-A write/status bundle.
interface framebuffer_loader_if;

  logic [7:0]                         rx_data;
  logic                               rx_valid;
  logic [fb_pkg::FB_BYTE_ADDR_W-1:0]  ram_addr;
  logic [7:0]                         ram_data;
  logic                               ram_wr;
  logic                               busy;
  logic                               frame_done;
  logic                               cmd_error;

  modport master (
    input  rx_data, rx_valid,
    output ram_addr, ram_data, ram_wr, busy, frame_done, cmd_error
  );

  modport slave (
    output rx_data, rx_valid,
    input  ram_addr, ram_data, ram_wr, busy, frame_done, cmd_error
  );

endinterface

// File: rtl/fbl_idle_timer.sv
// Inactivity counter: clears on request, counts while enabled, flags expiry.
module fbl_idle_timer #(
  parameter int unsigned              TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] IDLE_TIMEOUT  = 16'd53200
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  logic [TIMEOUT_WIDTH-1:0] count_q;

  assign expire_c = enable && !clear && (count_q == IDLE_TIMEOUT);

  // Holds at the limit; the owner drops enable on expiry.
  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !expire_c) begin
      count_q <= count_q + TIMEOUT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/framebuffer_loader.sv
// Decodes the UART frame/pixel command protocol into framebuffer port-A byte writes.
module framebuffer_loader
  import fb_pkg::*;
#(
  parameter logic [7:0]               CMD_FRAME     = CMD_FRAME_DEF,
  parameter logic [7:0]               CMD_PIXEL     = CMD_PIXEL_DEF,
  parameter int unsigned              TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] IDLE_TIMEOUT  = 16'd53200
) (
  input  logic                  clk_in,
  input  logic                  reset,
  framebuffer_loader_if.master  bus
);

  fbl_state_e                state_q, state_d;
  fb_wr_t                    wr_q, wr_d;
  logic                      ram_wr_q, ram_wr_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      busy_q;
  logic [FB_BYTE_ADDR_W-1:0] cnt_q, cnt_d;
  logic [FB_WORD_ADDR_W-1:0] idx_q, idx_d;
  logic                      expire_c;

  fbl_idle_timer #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .IDLE_TIMEOUT  (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_in   (clk_in),
    .reset    (reset),
    .clear    (bus.rx_valid || (state_q == IDLE)),
    .enable   (state_q != IDLE),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      ram_wr_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      ram_wr_q <= ram_wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  // A received byte always takes priority over a simultaneous timeout.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    ram_wr_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == CMD_FRAME) begin
            state_d = FRAME;
            cnt_d   = '0;
          end else if (bus.rx_data == CMD_PIXEL) begin
            state_d = PIX_AH;
          end else begin
            err_d = 1'b1;
          end
        end
        FRAME: begin
          wr_d     = '{addr: cnt_q, data: bus.rx_data};
          ram_wr_d = 1'b1;
          cnt_d    = cnt_q + FB_BYTE_ADDR_W'(1);
          if (cnt_q == FB_BYTE_ADDR_W'(FB_BYTES - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        PIX_AH: begin
          idx_d[10:8] = bus.rx_data[2:0];
          state_d     = PIX_AL;
        end
        PIX_AL: begin
          idx_d[7:0] = bus.rx_data;
          state_d    = PIX_DL;
        end
        PIX_DL: begin
          wr_d     = '{addr: {idx_q, 1'b0}, data: bus.rx_data};
          ram_wr_d = 1'b1;
          state_d  = PIX_DH;
        end
        PIX_DH: begin
          wr_d     = '{addr: {idx_q, 1'b1}, data: bus.rx_data};
          ram_wr_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (expire_c) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  assign bus.ram_addr   = wr_q.addr;
  assign bus.ram_data   = wr_q.data;
  assign bus.ram_wr     = ram_wr_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.cmd_error  = err_q;

endmodule

// File: tb/tb_framebuffer_loader.sv
// Scoreboard bench for framebuffer_loader: directed command sequences, queued expected writes.
module tb_framebuffer_loader;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  framebuffer_loader_if bus ();

  framebuffer_loader dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   exp_err    = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   wr_count   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d, input logic done);
    exp_t x;
    x.addr = a;
    x.data = d;
    x.done = done;
    exp_q.push_back(x);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk_in);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || exp_err != 0); i++) idle(1);
    chk({name, "_pending_wr"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_pending_err"}, 32'(exp_err), 32'd0);
  endtask

  // Monitor: pops on every write, tracks expected error pulses.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (bus.ram_wr) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, expected no write", bus.ram_addr, bus.ram_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.ram_data), 32'(e.data));
          chk("wr_done", 32'(bus.frame_done), 32'(e.done));
        end
      end else if (bus.frame_done) begin
        compared++;
        mismatched++;
        $display("FAIL stray_frame_done: got 1 without ram_wr, expected 0");
      end
      if (bus.cmd_error) begin
        compared++;
        if (exp_err == 0) begin
          mismatched++;
          $display("FAIL unexpected_cmd_error: got 1, expected 0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  initial begin
    int base;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_data", 32'(bus.ram_data), 32'd0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_cmd_error", 32'(bus.cmd_error), 32'd0);
    reset = 1'b0;
    idle(2);

    // Full frame, one byte every 4 cycles.
    send(8'h46);
    chk("frame_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4096; i++) begin
      push_wr(12'(i), 8'(i), i == 4095);
      send(8'(i));
      idle(3);
    end
    drain("frame", 10);
    chk("frame_busy_after", 32'(bus.busy), 32'd0);

    // Single pixel at index 0x7FF.
    send(8'h50);
    send(8'h07);
    send(8'hFF);
    push_wr(12'hFFE, 8'h34, 1'b0);
    send(8'h34);
    push_wr(12'hFFF, 8'h12, 1'b1);
    send(8'h12);
    drain("pixel", 10);
    chk("pixel_busy_after", 32'(bus.busy), 32'd0);

    // Unknown command, then a pixel command still works.
    exp_err++;
    send(8'h41);
    chk("unknown_busy", 32'(bus.busy), 32'd0);
    drain("unknown", 5);
    send(8'h50);
    send(8'h00);
    send(8'h10);
    push_wr(12'h020, 8'h5A, 1'b0);
    send(8'h5A);
    push_wr(12'h021, 8'hA5, 1'b1);
    send(8'hA5);
    drain("pixel2", 10);

    // Partial frame then silence until timeout abort.
    send(8'h46);
    for (int i = 0; i < 10; i++) begin
      push_wr(12'(i), 8'(8'hC0 + i), 1'b0);
      send(8'(8'hC0 + i));
    end
    exp_err++;
    drain("timeout", 53300);
    chk("timeout_busy", 32'(bus.busy), 32'd0);

    // Restart at address 0 with back-to-back bytes.
    send(8'h46);
    base = wr_count;
    for (int i = 0; i < 4096; i++) begin
      push_wr(12'(i), 8'(i ^ 8'h3C), i == 4095);
      send(8'(i ^ 8'h3C));
    end
    idle(2);
    chk("b2b_wr_count", 32'(wr_count - base), 32'd4096);
    drain("b2b", 10);
    chk("b2b_busy_after", 32'(bus.busy), 32'd0);

    // Reset mid-command discards the partial pixel command.
    send(8'h50);
    send(8'h01);
    reset = 1'b1;
    idle(1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("midrst_ram_addr", 32'(bus.ram_addr), 32'd0);
    reset = 1'b0;
    idle(1);
    send(8'h50);
    send(8'h00);
    send(8'h00);
    push_wr(12'h000, 8'hAA, 1'b0);
    send(8'hAA);
    push_wr(12'h001, 8'hBB, 1'b1);
    send(8'hBB);
    drain("postrst", 10);
    chk("postrst_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/framebuffer_loader.md
Name: framebuffer_loader

Overview:
Upstream writer for the framebuffer's byte-wide port A (12-bit address, 8-bit data). It consumes received UART bytes (data plus a one-cycle strobe from the UART receiver) and decodes a small command protocol. It writes either a full 64x32 RGB565 frame or a single pixel into the framebuffer. It runs on the root clock alongside the control module, and the matrix read side (port B) is unaffected.

Parameters:
- CMD_FRAME, 8'h46, command byte that starts a full-frame load.
- CMD_PIXEL, 8'h50, command byte that starts a single-pixel write.
- IDLE_TIMEOUT, 16'd53200, clk_in cycles without rx_valid mid-command before abort (about 1 ms at 53.2 MHz).
- TIMEOUT_WIDTH, 16, width of the inactivity counter.

Ports:
- clk_in  input  1  root clock; all logic rising-edge.
- reset  input  1  synchronous, active-high.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- ram_addr  output  12  framebuffer port A byte address.
- ram_data  output  8  framebuffer port A write data.
- ram_wr  output  1  write strobe, one cycle per byte; drives WrA and ClockEnA.
- busy  output  1  high while a command is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse after the last byte of a frame or pixel command is written.
- cmd_error  output  1  one-cycle pulse on an unknown command byte or on timeout abort.

Behaviour:
- Interface: one clock (clk_in); reset is synchronous and active-high.
- Reset values: ram_addr=0, ram_data=0, ram_wr=0, busy=0, frame_done=0, cmd_error=0, state=IDLE, timeout counter=0.
- Byte mapping:
  - Byte address 2n is bits [7:0] of RGB565 word n; byte address 2n+1 is bits [15:8].
  - Word n = {half, row[3:0], col[5:0]}, which matches the port B read address.
- State IDLE, on rx_valid:
  - byte == CMD_FRAME: go to FRAME, byte counter=0.
  - byte == CMD_PIXEL: go to PIX_AH.
  - any other byte: pulse cmd_error for one cycle and stay in IDLE.
- State FRAME:
  - Each rx_valid registers ram_addr=counter, ram_data=rx_data, ram_wr=1 on the next cycle (1-cycle latency), then increments the counter.
  - On the byte at counter 4095: return to IDLE and pulse frame_done in the same cycle as that byte's ram_wr.
  - The 12-bit counter must not wrap into a second frame.
- Pixel command sequence:
  - PIX_AH captures pixel index bits [10:8] from rx_data[2:0]; rx_data[7:3] is ignored.
  - PIX_AL captures bits [7:0].
  - PIX_DL writes byte address {index,1'b0}.
  - PIX_DH writes byte address {index,1'b1}, then returns to IDLE with frame_done coincident with that write.
- Inactivity timeout:
  - The counter clears on every rx_valid and while in IDLE.
  - In any non-IDLE state it increments each cycle.
  - On reaching IDLE_TIMEOUT: return to IDLE, pulse cmd_error, no write. Bytes already written stay written.
- Simultaneous events: when rx_valid and the timeout occur in the same cycle, rx_valid wins; the byte is processed and the counter clears.
- Strobe ordering: ram_wr, frame_done and cmd_error are single-cycle pulses. Back-to-back rx_valid on consecutive cycles must give back-to-back writes with no byte dropped.
- Command bytes inside FRAME or PIX_* states are treated as data; there is no escape sequence.
- Reset mid-command: the next cycle is IDLE, all outputs return to reset values, and no partial write is emitted after reset.
- ram_addr and ram_data hold their last value when ram_wr=0.

Decomposition:
- Shared package fb_pkg:
  - FB_BYTE_ADDR_W=12, FB_WORD_ADDR_W=11, FB_BYTES=4096.
  - CMD_FRAME and CMD_PIXEL defaults.
  - State enum: IDLE, FRAME, PIX_AH, PIX_AL, PIX_DL, PIX_DH.
- One sub-module: fbl_idle_timer (clear / enable / expire counter, parameterised by TIMEOUT_WIDTH and IDLE_TIMEOUT).

Test Plan:
- Reset, then 0x46 followed by 4096 bytes (value = addr[7:0]) at one byte per 4 cycles -> 4096 ram_wr pulses with ram_addr 0..4095 and ram_data = addr[7:0]; frame_done exactly once, with the write to 4095; busy=0 afterwards.
- 0x50,0x07,0xFF,0x34,0x12 -> writes (0xFFE,0x34) then (0xFFF,0x12); frame_done with the second write; no other ram_wr.
- Unknown byte 0x41 in IDLE -> cmd_error pulse, no ram_wr, busy stays 0; a following 0x50 sequence still works.
- 0x46 plus 10 bytes, then silence for IDLE_TIMEOUT cycles -> exactly 10 writes, cmd_error pulse, busy=0; the next 0x46 restarts at address 0.
- 0x46 then rx_valid on 4096 consecutive cycles -> 4096 consecutive ram_wr cycles, none dropped.
- reset asserted after 0x50,0x01 -> no ram_wr, busy=0 the next cycle; the next 0x50,0x00,0x00,0xAA,0xBB writes addresses 0 and 1.
